// File: rtl/full_adder_if.sv
// Operand/result bundle for full_adder: operands with their valid qualifier in one
// direction, registered result and status flags with their valid in the other.
interface full_adder_if #(
    parameter int WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;
    logic             out_valid;

    modport master (
        output in_valid, a, b, cin,
        input  sum, cout, ovf, zero, out_valid
    );

    modport slave (
        input  in_valid, a, b, cin,
        output sum, cout, ovf, zero, out_valid
    );
endinterface

// File: rtl/full_adder.sv
// Registered WIDTH-bit ripple-carry adder with carry/overflow/zero flags and valid tracking.
// Optional input register stage when FULL_ADDER_IN_REG_EN is defined (latency 2 instead of 1).
module full_adder #(
    parameter int WIDTH = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    full_adder_if.slave  bus
);

    // Operands as seen by the carry chain: straight from the ports or from the input stage.
    logic             stage_valid;
    logic [WIDTH-1:0] stage_a;
    logic [WIDTH-1:0] stage_b;
    logic             stage_cin;

`ifdef FULL_ADDER_IN_REG_EN
    // NOTE: sequential state uses non-blocking assignments and an async active-low reset,
    // so every register clears the instant rst_n falls, discarding in-flight work.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_valid <= 1'b0;
            stage_a     <= '0;
            stage_b     <= '0;
            stage_cin   <= 1'b0;
        end else begin
            stage_valid <= bus.in_valid;
            if (bus.in_valid) begin
                stage_a   <= bus.a;
                stage_b   <= bus.b;
                stage_cin <= bus.cin;
            end
        end
    end
`else
    assign stage_valid = bus.in_valid;
    assign stage_a     = bus.a;
    assign stage_b     = bus.b;
    assign stage_cin   = bus.cin;
`endif

    // Ripple chain: carry[i] enters cell i, carry[WIDTH] leaves the MSB.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] s;

    assign carry[0] = stage_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign s[i]       = stage_a[i] ^ stage_b[i] ^ carry[i];
        assign carry[i+1] = (stage_a[i] & stage_b[i])
                          | (stage_a[i] & carry[i])
                          | (stage_b[i] & carry[i]);
    end

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             zero_q;
    logic             out_valid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= stage_valid;
            // NOTE: results load only on a valid operand, so idle (possibly X) inputs never
            // reach the outputs; zero is taken from the value being loaded, not the old sum.
            if (stage_valid) begin
                sum_q  <= s;
                cout_q <= carry[WIDTH];
                ovf_q  <= carry[WIDTH] ^ carry[WIDTH-1];
                zero_q <= (s == '0);
            end
        end
    end

    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_full_adder.sv
// Randomized + directed bench for full_adder at WIDTH=1 and WIDTH=8 against an arithmetic model.
// Honours FULL_ADDER_IN_REG_EN for the expected latency.
module tb_full_adder;

`ifdef FULL_ADDER_IN_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    full_adder_if #(.WIDTH(1)) if1 ();
    full_adder_if #(.WIDTH(8)) if8 ();

    full_adder #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    full_adder #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));

    typedef struct packed {
        logic        v;
        logic [63:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // Reference: plain integer arithmetic, signed overflow from the true signed sum's range.
    function automatic res_t ref_add(input int w, input logic [63:0] a, input logic [63:0] b,
                                     input logic c);
        res_t                r;
        logic [63:0]         mask;
        logic [64:0]         full;
        logic signed [65:0]  sa, sb, t, lim;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        full = {1'b0, a & mask} + {1'b0, b & mask} + {64'd0, c};
        r.v  = 1'b1;
        r.s  = full[63:0] & mask;
        r.co = full[7'(w)];
        r.z  = (r.s == 64'd0);
        lim  = 66'sd1 <<< (w - 1);
        sa   = $signed({2'b00, a & mask});
        sb   = $signed({2'b00, b & mask});
        if (a[6'(w - 1)]) sa = sa - (lim <<< 1);
        if (b[6'(w - 1)]) sb = sb - (lim <<< 1);
        t    = sa + sb + $signed({65'd0, c});
        r.ov = (t >= lim) || (t < -lim);
        return r;
    endfunction

    // Model pipeline: new result enters stage 0, expected outputs follow stage LAT-1.
    res_t n_new [2];
    res_t pipe  [2][LAT];
    res_t held  [2];
    res_t exp_q [2];

    always_comb begin
        n_new[0] = '0;
        n_new[1] = '0;
        if (if1.in_valid === 1'b1) n_new[0] = ref_add(1, 64'(if1.a), 64'(if1.b), if1.cin);
        if (if8.in_valid === 1'b1) n_new[1] = ref_add(8, 64'(if8.a), 64'(if8.b), if8.cin);
    end

    always_comb begin
        for (int d = 0; d < 2; d++) begin
            exp_q[d]   = pipe[d][LAT-1].v ? pipe[d][LAT-1] : held[d];
            exp_q[d].v = pipe[d][LAT-1].v;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                held[d] <= '0;
                for (int k = 0; k < LAT; k++) pipe[d][k] <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                held[d]    <= exp_q[d];
                pipe[d][0] <= n_new[d];
                for (int k = 1; k < LAT; k++) pipe[d][k] <= pipe[d][k-1];
            end
        end
    end

    task automatic compare_all();
        check("w1.out_valid", 64'(if1.out_valid), 64'(exp_q[0].v));
        check("w1.sum",       64'(if1.sum),       exp_q[0].s);
        check("w1.cout",      64'(if1.cout),      64'(exp_q[0].co));
        check("w1.ovf",       64'(if1.ovf),       64'(exp_q[0].ov));
        check("w1.zero",      64'(if1.zero),      64'(exp_q[0].z));
        check("w8.out_valid", 64'(if8.out_valid), 64'(exp_q[1].v));
        check("w8.sum",       64'(if8.sum),       exp_q[1].s);
        check("w8.cout",      64'(if8.cout),      64'(exp_q[1].co));
        check("w8.ovf",       64'(if8.ovf),       64'(exp_q[1].ov));
        check("w8.zero",      64'(if8.zero),      64'(exp_q[1].z));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive1(input logic v, input logic a, input logic b, input logic c);
        if1.in_valid = v; if1.a = a; if1.b = b; if1.cin = c;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        if8.in_valid = v; if8.a = a; if8.b = b; if8.cin = c;
    endtask

    // Present one valid 8-bit add, then idle until its result is on the outputs.
    task automatic add8(input logic [7:0] a, input logic [7:0] b, input logic c);
        drive8(1'b1, a, b, c);
        tick();
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (LAT - 1) tick();
    endtask

    logic [1:0] tbl [8];
    int         pulses;

    initial begin
        tbl = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
        rst_n = 1'b0;
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        #1;
        compare_all();
        check("reset.sum8_const", 64'(if8.sum), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        compare_all();

        // WIDTH=1 truth-table sweep, one vector per cycle.
        for (int i = 0; i < 8 + LAT - 1; i++) begin
            if (i < 8) drive1(1'b1, i[2], i[1], i[0]);
            else       drive1(1'b0, 1'b0, 1'b0, 1'b0);
            tick();
            if (i >= LAT - 1) begin
                check("sweep.valid", 64'(if1.out_valid), 64'd1);
                check("sweep.cout_sum", 64'({if1.cout, if1.sum}), 64'(tbl[i - LAT + 1]));
            end
        end
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Boundary: all-ones plus carry wraps to zero.
        add8(8'hFF, 8'h00, 1'b1);
        check("ff.sum", 64'(if8.sum), 64'h00);
        check("ff.cout", 64'(if8.cout), 64'd1);
        check("ff.zero", 64'(if8.zero), 64'd1);
        check("ff.ovf", 64'(if8.ovf), 64'd0);

        // Boundary: positive overflow into the sign bit.
        add8(8'h7F, 8'h01, 1'b0);
        check("7f.sum", 64'(if8.sum), 64'h80);
        check("7f.cout", 64'(if8.cout), 64'd0);
        check("7f.ovf", 64'(if8.ovf), 64'd1);
        check("7f.zero", 64'(if8.zero), 64'd0);

        // Single valid, then idle with changing and unknown operands.
        drive8(1'b1, 8'd3, 8'd4, 1'b0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pulses += int'(if8.out_valid);
            if (i < 3) drive8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            else begin
                if8.in_valid = 1'b0; if8.a = 'x; if8.b = 'x; if8.cin = 1'bx;
                if1.in_valid = 1'b0; if1.a = 'x; if1.b = 'x; if1.cin = 1'bx;
            end
        end
        check("hold.pulses", 64'(pulses), 64'd1);
        check("hold.sum", 64'(if8.sum), 64'd7);
        drive1(1'b0, 1'b0, 1'b0, 1'b0);

        // Async reset mid-cycle with an operation in flight.
        add8(8'h50, 8'h05, 1'b0);
        check("pre_rst.sum", 64'(if8.sum), 64'h55);
        drive8(1'b1, 8'h11, 8'h22, 1'b0);
        drive1(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        compare_all();
        check("rst.sum", 64'(if8.sum), 64'd0);
        check("rst.valid", 64'(if8.out_valid), 64'd0);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (LAT + 2) begin
            tick();
            pulses += int'(if8.out_valid) + int'(if1.out_valid);
        end
        check("post_rst.pulses", 64'(pulses), 64'd0);
        add8(8'h30, 8'h0C, 1'b1);
        check("post_rst.sum", 64'(if8.sum), 64'h3D);

        // Random traffic on both widths.
        for (int i = 0; i < 400; i++) begin
            drive1($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom), 1'($urandom));
            drive8($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 1'($urandom));
            tick();
        end
        drive1(1'b0, 1'b0, 1'b0, 1'b0);
        drive8(1'b0, 8'h00, 8'h00, 1'b0);
        repeat (LAT + 1) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/full_adder.md
# full_adder

Registered WIDTH-bit ripple-carry adder built from per-bit full-adder cells, with a valid-qualified single-cycle pipeline and status flags. It is the arithmetic leaf used wherever a carry-in/carry-out add is needed. With WIDTH=1 it behaves as a classic 1-bit full adder whose outputs are registered.

## Interface
- WIDTH, default 1: operand width in bits; legal range 1..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  qualifies a, b and cin this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in.
- sum  output  WIDTH  registered a + b + cin, modulo 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.
- ovf  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- zero  output  1  registered flag, high when sum == 0.
- out_valid  output  1  sum, cout, ovf and zero hold a new result this cycle.

## Operation
- Combinational core is a ripple chain of WIDTH full-adder cells:
  - s[i] = a[i] ^ b[i] ^ c[i]
  - c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i]
  - c[0] = cin; cout = c[WIDTH].
- {cout, sum} equals the (WIDTH+1)-bit value a + b + cin; no saturation.
- ovf = c[WIDTH] ^ c[WIDTH-1].
  - WIDTH=1: ovf = cout ^ cin.
- zero is computed from the result being registered, not from the previous sum.
- Result registers load only when in_valid=1.
  - With in_valid=0 they hold their last value and out_valid drops to 0.
- No backpressure; every valid input produces exactly one out_valid pulse.

## Timing
- Reset (rst_n=0, asynchronous): sum=0, cout=0, ovf=0, zero=0, out_valid=0 immediately, independent of clk.
- Release of rst_n is sampled at clk; the first capture happens on the first rising edge with rst_n=1.
- Latency: inputs sampled at edge N appear on outputs after edge N, with out_valid=1 during cycle N+1.
  - Latency is 2 edges when FULL_ADDER_IN_REG_EN is defined.
- Throughput: one add per cycle.
  - Back-to-back in_valid produces back-to-back out_valid.
- Reset mid-operation: any in-flight operation is discarded; no out_valid is produced for it.
- X on a, b or cin while in_valid=0 must not reach the outputs.

## Configuration
- FULL_ADDER_IN_REG_EN defined:
  - Adds an input register stage for a, b, cin and in_valid, reset to 0, ahead of the adder chain.
  - Latency becomes 2 cycles and throughput stays 1 per cycle.
  - The flush-on-reset rule also applies to this stage.
- FULL_ADDER_IN_REG_EN undefined: the adder chain is fed directly from the ports; latency is 1 cycle.

## Test plan
- WIDTH=1, in_valid=1, sweep {a,b,cin} through 000..111, one per cycle:
  - {cout,sum} = 00,01,01,10,01,10,10,11 in order, out_valid=1 each cycle, one cycle later (two with the macro).
- WIDTH=8, a=8'hFF, b=8'h00, cin=1:
  - sum=8'h00, cout=1, zero=1, ovf=0.
- WIDTH=8, a=8'h7F, b=8'h01, cin=0:
  - sum=8'h80, cout=0, ovf=1, zero=0.
- Assert in_valid for one cycle with a=3, b=4, then hold in_valid=0 while changing a and b:
  - out_valid pulses once, and sum stays 7 afterwards.
- Drive rst_n=0 asynchronously mid-cycle while outputs hold sum=8'h55, then in_valid=1 in the cycle before reset:
  - All outputs go to 0 at once, no out_valid follows after reset release, and the next valid add produces the correct result.
